// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning action scheduler: FSM states and LFSR constants.
package qlearn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/qlearn_action_sched_if.sv
// Handshake/config bundle between the action scheduler (slave) and its controller/pipeline (master).
interface qlearn_action_sched_if #(
  parameter int ACT_W  = 3,
  parameter int FX_W   = 8,
  parameter int STEP_W = 16
);
  logic              cfg_we;
  logic [FX_W-1:0]   cfg_alpha;
  logic [FX_W-1:0]   cfg_gamma;
  logic [7:0]        cfg_eps;
  logic [STEP_W-1:0] num_steps;
  logic              start;
  logic              abort;
  logic              pipe_ready;
  logic [ACT_W-1:0]  greedy_action;
  logic [ACT_W-1:0]  action;
  logic              action_valid;
  logic [FX_W-1:0]   alpha;
  logic [FX_W-1:0]   gamma;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] step_count;

  modport master (
    output cfg_we, cfg_alpha, cfg_gamma, cfg_eps, num_steps, start, abort,
           pipe_ready, greedy_action,
    input  action, action_valid, alpha, gamma, busy, done, step_count
  );

  modport slave (
    input  cfg_we, cfg_alpha, cfg_gamma, cfg_eps, num_steps, start, abort,
           pipe_ready, greedy_action,
    output action, action_valid, alpha, gamma, busy, done, step_count
  );
endinterface

// File: rtl/qlearn_lfsr16.sv
// 16-bit Galois LFSR (right-shifting, mask LFSR_POLY); advances once per enabled cycle.
module qlearn_lfsr16
  import qlearn_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_POLY : '0);
    end
  end

endmodule

// File: rtl/qlearn_action_sched.sv
// Episode scheduler issuing actions to a Q-learning update pipeline.
// Define QLEARN_EPS_GREEDY_EN for epsilon-greedy selection; otherwise selection is pure random.
module qlearn_action_sched
  import qlearn_pkg::*;
#(
  parameter int          ACT_W      = 3,
  parameter int          FX_W       = 8,
  parameter int          STEP_W     = 16,
  parameter int          PIPE_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  qlearn_action_sched_if.slave sif
);

  localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  state_t              state, state_nxt;
  logic [FX_W-1:0]     alpha_q, gamma_q;
  logic [STEP_W-1:0]   target_q, step_q, step_inc;
  logic [DRAIN_W-1:0]  drain_q;
  logic [15:0]         lfsr_q;
  logic [ACT_W-1:0]    sel_action;
  logic                issue, start_ok, last_issue, drain_last;

  qlearn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (issue),
    .q   (lfsr_q)
  );

`ifdef QLEARN_EPS_GREEDY_EN
  logic [7:0] eps_q;
  logic       unused_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eps_q <= '0;
    end else if (state == ST_IDLE && sif.cfg_we) begin
      eps_q <= sif.cfg_eps;
    end
  end

  // Explore when the LFSR high byte falls below eps, otherwise exploit.
  assign sel_action  = (lfsr_q[15:8] < eps_q) ? lfsr_q[ACT_W-1:0] : sif.greedy_action;
  assign unused_bits = ^lfsr_q;
`else
  logic unused_bits;

  assign sel_action  = lfsr_q[ACT_W-1:0];
  assign unused_bits = ^{lfsr_q, sif.cfg_eps, sif.greedy_action};
`endif

  assign step_inc   = step_q + STEP_W'(1);
  assign last_issue = (step_inc == target_q);
  assign drain_last = (drain_q == DRAIN_W'(PIPE_DEPTH - 1));
  assign start_ok   = (state == ST_IDLE) && sif.start && !sif.abort;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = (sif.num_steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (sif.abort) begin
          state_nxt = ST_IDLE;
        end else if (issue && last_issue) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sif.abort) begin
          state_nxt = ST_IDLE;
        end else if (drain_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue            = (state == ST_RUN) && sif.pipe_ready && !sif.abort;
    sif.action_valid = issue;
    sif.action       = issue ? sel_action : '0;
    sif.busy         = (state == ST_RUN) || (state == ST_DRAIN);
    sif.done         = (state == ST_DONE) && !sif.abort;
  end

  // Datapath: coefficients, episode length, step and drain counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alpha_q  <= '0;
      gamma_q  <= '0;
      target_q <= '0;
      step_q   <= '0;
      drain_q  <= '0;
    end else begin
      if (state == ST_IDLE && sif.cfg_we) begin
        alpha_q <= sif.cfg_alpha;
        gamma_q <= sif.cfg_gamma;
      end
      if (start_ok) begin
        target_q <= sif.num_steps;
        step_q   <= '0;
      end else if (issue) begin
        step_q <= step_inc;
      end
      drain_q <= (state == ST_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
    end
  end

  assign sif.alpha      = alpha_q;
  assign sif.gamma      = gamma_q;
  assign sif.step_count = step_q;

endmodule

// File: doc/qlearn_action_sched.md
QLEARN_ACTION_SCHED -- requirements
Module: qlearn_action_sched

Interface
REQ-001 Parameter ACT_W, default 3, action index width (8 actions).
REQ-002 Parameter FX_W, default 8, fixed-point width of alpha/gamma (4.4 format; 8'b0000_0010 = 0.125).
REQ-003 Parameter STEP_W, default 16, step counter width.
REQ-004 Parameter PIPE_DEPTH, default 4, update-pipeline latency in cycles, drained before done; minimum 1.
REQ-005 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 cfg_we  in  1  load cfg_alpha/cfg_gamma/cfg_eps (honoured in IDLE only).
REQ-009 cfg_alpha, cfg_gamma  in  FX_W each  learning rate, discount factor.
REQ-010 cfg_eps  in  8  exploration threshold (0 = always greedy, 255 = almost always random).
REQ-011 num_steps  in  STEP_W  steps per episode, sampled on start.
REQ-012 start  in  1  begin episode (IDLE only); abort  in  1  cancel episode.
REQ-013 pipe_ready  in  1  pipeline accepts an action this cycle.
REQ-014 greedy_action  in  ACT_W  argmax action from pipeline.
REQ-015 action  out  ACT_W; action_valid  out  1  issue strobe to pipeline.
REQ-016 alpha, gamma  out  FX_W  registered coefficients driving pipeline.
REQ-017 busy  out  1; done  out  1 (one-cycle pulse); step_count  out  STEP_W.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; encoding in shared package.
REQ-019 IDLE: cfg_we=1 registers cfg_* into alpha/gamma/eps next cycle; cfg_we outside IDLE ignored.
REQ-020 IDLE & start: latch num_steps, clear step_count; go RUN, or DONE directly if num_steps==0.
REQ-021 RUN: each cycle with pipe_ready=1, action_valid=1 and action issued same cycle (combinational on registered state); step_count increments at that edge.
REQ-022 RUN & pipe_ready=0: action_valid=0, LFSR and step_count hold.
REQ-023 Action selection: random = LFSR[ACT_W-1:0]; chosen if LFSR[15:8] < eps, else greedy_action.
REQ-024 LFSR: 16-bit Galois, polynomial mask 16'hB400, shifts once per issued action.
REQ-025 Issue resulting in step_count==num_steps -> DRAIN; no further action_valid.
REQ-026 DRAIN counts PIPE_DEPTH cycles then DONE; DONE asserts done one cycle, returns to IDLE.
REQ-027 busy=1 in RUN and DRAIN, 0 otherwise.
REQ-028 abort=1 in any non-IDLE state: next state IDLE, no done pulse, action_valid=0 that cycle; step_count holds last value.
REQ-029 abort and start together in IDLE: abort wins, stay IDLE.
REQ-030 step_count saturates by construction at num_steps; no wrap.

Reset
REQ-031 rst=0: state IDLE, action=0, action_valid=0, busy=0, done=0, step_count=0, alpha=gamma=0, eps=0, LFSR=LFSR_SEED; mid-episode reset abandons episode immediately.

Configuration
REQ-032 Macro QLEARN_EPS_GREEDY_EN defined: selection per REQ-023.
REQ-033 Macro absent: action always LFSR[ACT_W-1:0] (pure random exploration); greedy_action and cfg_eps unused, eps register removed.

Structure
REQ-034 Package qlearn_pkg holds FSM state enum, LFSR polynomial mask constant, default LFSR seed.
REQ-035 LFSR is sub-module qlearn_lfsr16 (ports clk, rst, en, q[15:0]).

Verification
REQ-036 Reset, cfg_we with alpha=8'h02, gamma=8'h02 in IDLE -> alpha/gamma=8'h02 next cycle; same cfg_we during RUN -> values unchanged.
REQ-037 Greedy build, eps=0, greedy_action=5, num_steps=10, pipe_ready=1 -> ten consecutive action_valid with action=5, done pulse exactly PIPE_DEPTH+1 cycles after last issue.
REQ-038 eps=255 (or macro undefined), num_steps=20 -> actions equal reference-model Galois LFSR from 16'hACE1 low 3 bits; step_count=20 at done.
REQ-039 num_steps=6, pipe_ready toggling 1,0,1,0 -> exactly 6 issues, none while pipe_ready=0, LFSR frozen in stall cycles.
REQ-040 abort in RUN after 3 issues -> IDLE next cycle, no done, step_count=3; start with num_steps=0 -> done one cycle after start, no action_valid.
REQ-041 rst asserted mid-DRAIN -> all outputs at reset values asynchronously; fresh episode then runs normally.
